// File: rtl/ram_sync_clear.sv
// Single-port synchronous RAM that clears every word to CLEAR_VALUE after reset or on request.
// Accesses are ignored while the clear sweep runs; dropped writes are flagged on wr_drop.
module ram_sync_clear #(
  parameter int unsigned     WIDTH       = 16,
  parameter int unsigned     ADDR_W      = 14,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              rd_en,
  input  logic              clear_req,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy,
  output logic              wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              rd_fire;
  logic              wr_fwd;
  logic              wr_drop_d;

  logic [WIDTH-1:0]  out_q;
  logic              out_valid_q;
  logic              wr_drop_q;

  // State register and sweep counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next-state logic: sweep runs exactly DEPTH cycles, clear_req only honoured in READY
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  // Output/datapath decode; clear_req in READY suppresses the access at that edge
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = in;
    rd_fire   = 1'b0;
    wr_fwd    = 1'b0;
    wr_drop_d = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = CLEAR_VALUE;
        wr_drop_d = load;
      end
      READY: begin
        if (clear_req) begin
          wr_drop_d = load;
        end else begin
          mem_we  = load;
          rd_fire = rd_en;
          wr_fwd  = load;
        end
      end
      default: begin
        wr_drop_d = load;
      end
    endcase
  end

  // Memory array carries no reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Registered read port, write-first on a same-cycle load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      out_valid_q <= rd_fire;
      wr_drop_q   <= wr_drop_d;
      if (rd_fire) begin
        out_q <= wr_fwd ? in : mem[address];
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign wr_drop   = wr_drop_q;
  assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_sync_clear.sv
// Directed bench for ram_sync_clear with ADDR_W=4, WIDTH=16, CLEAR_VALUE=16'hA5A5.
module tb_ram_sync_clear;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam logic [15:0] CV     = 16'hA5A5;

  logic              clk;
  logic              reset_n;
  logic [WIDTH-1:0]  din;
  logic [ADDR_W-1:0] addr;
  logic              load;
  logic              rd_en;
  logic              clear_req;
  logic [WIDTH-1:0]  dout;
  logic              out_valid;
  logic              busy;
  logic              wr_drop;

  int checks;
  int failures;

  ram_sync_clear #(
    .WIDTH      (WIDTH),
    .ADDR_W     (ADDR_W),
    .CLEAR_VALUE(CV)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in       (din),
    .address  (addr),
    .load     (load),
    .rd_en    (rd_en),
    .clear_req(clear_req),
    .out      (dout),
    .out_valid(out_valid),
    .busy     (busy),
    .wr_drop  (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    din       = '0;
    addr      = '0;
    load      = 1'b0;
    rd_en     = 1'b0;
    clear_req = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || dout !== 16'h0000 || out_valid !== 1'b0 || wr_drop !== 1'b0) begin
      failures++;
      $display("FAIL reset_state busy=%b out=%h out_valid=%b wr_drop=%b exp busy=1 out=0000 valid=0 drop=0",
               busy, dout, out_valid, wr_drop);
    end
  endtask

  task automatic test_initial_sweep();
    int bad_busy;
    int bad_drop;
    bad_busy = 0;
    bad_drop = 0;
    #11;
    reset_n = 1'b1;
    load    = 1'b1;
    din     = 16'hFFFF;
    addr    = 4'd5;
    for (int i = 1; i <= 16; i++) begin
      if (busy !== 1'b1) bad_busy++;
      tick();
      if (wr_drop !== 1'b1) bad_drop++;
    end
    load = 1'b0;
    checks++;
    if (bad_busy != 0) begin
      failures++;
      $display("FAIL sweep_busy cycles_not_busy=%0d exp 0", bad_busy);
    end
    checks++;
    if (bad_drop != 0) begin
      failures++;
      $display("FAIL sweep_wr_drop cycles_without_pulse=%0d exp 0", bad_drop);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL sweep_end busy=%b exp 0", busy);
    end
    for (int a = 0; a < 16; a++) begin
      addr  = ADDR_W'(a);
      rd_en = 1'b1;
      tick();
      checks++;
      if (dout !== CV || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL sweep_read addr=%0d out=%h valid=%b exp %h valid=1", a, dout, out_valid, CV);
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || wr_drop !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_read valid=%b wr_drop=%b exp 0 0", out_valid, wr_drop);
    end
  endtask

  task automatic test_write_read();
    addr = 4'd3;
    din  = 16'h1234;
    load = 1'b1;
    tick();
    load  = 1'b0;
    rd_en = 1'b1;
    tick();
    checks++;
    if (dout !== 16'h1234 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL write_read out=%h valid=%b exp 1234 valid=1", dout, out_valid);
    end
    rd_en = 1'b0;
    addr  = 4'd9;
    tick();
    checks++;
    if (dout !== 16'h1234 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_hold out=%h valid=%b exp 1234 valid=0", dout, out_valid);
    end
  endtask

  task automatic test_write_first();
    addr = 4'd7;
    din  = 16'h0001;
    load = 1'b1;
    tick();
    din   = 16'hBEEF;
    rd_en = 1'b1;
    tick();
    checks++;
    if (dout !== 16'hBEEF || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL write_first out=%h valid=%b exp beef valid=1", dout, out_valid);
    end
    load = 1'b0;
    tick();
    checks++;
    if (dout !== 16'hBEEF) begin
      failures++;
      $display("FAIL write_first_stored out=%h exp beef", dout);
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_clear_req();
    int bad_busy;
    int drops;
    bad_busy = 0;
    drops    = 0;
    addr      = 4'd2;
    din       = 16'h5555;
    load      = 1'b1;
    clear_req = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || wr_drop !== 1'b1) begin
      failures++;
      $display("FAIL clear_start busy=%b wr_drop=%b exp 1 1", busy, wr_drop);
    end
    load      = 1'b0;
    clear_req = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      clear_req = (i == 5);
      tick();
      if (busy !== 1'b1) bad_busy++;
      if (wr_drop === 1'b1) drops++;
    end
    clear_req = 1'b0;
    tick();
    checks++;
    if (bad_busy != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_len early_drop=%0d busy_after_16=%b exp 0 0", bad_busy, busy);
    end
    checks++;
    if (drops != 0) begin
      failures++;
      $display("FAIL clear_drop_once extra_pulses=%0d exp 0", drops);
    end
    addr  = 4'd2;
    rd_en = 1'b1;
    tick();
    checks++;
    if (dout !== CV || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_read addr=2 out=%h valid=%b exp %h valid=1", dout, out_valid, CV);
    end
    addr = 4'd3;
    tick();
    checks++;
    if (dout !== CV) begin
      failures++;
      $display("FAIL clear_read addr=3 out=%h exp %h", dout, CV);
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    int bad_busy;
    bad_busy = 0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    load      = 1'b1;
    din       = 16'h7777;
    for (int i = 1; i <= 9; i++) tick();
    checks++;
    if (wr_drop !== 1'b1 || dout !== CV || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset wr_drop=%b out=%h busy=%b exp 1 %h 1", wr_drop, dout, busy, CV);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dout !== 16'h0000 || out_valid !== 1'b0 || wr_drop !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL async_reset out=%h valid=%b wr_drop=%b busy=%b exp 0000 0 0 1",
               dout, out_valid, wr_drop, busy);
    end
    load = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (busy !== 1'b1) bad_busy++;
    end
    tick();
    checks++;
    if (bad_busy != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_resweep early_drop=%0d busy_after_16=%b exp 0 0", bad_busy, busy);
    end
    addr  = 4'd0;
    rd_en = 1'b1;
    tick();
    checks++;
    if (dout !== CV || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_resweep_read out=%h valid=%b exp %h 1", dout, out_valid, CV);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dout !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_access valid=%b out=%h exp 0 0000", out_valid, dout);
    end
    rd_en = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_busy_read_ignored();
    tick();
    addr  = 4'd4;
    rd_en = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || dout !== 16'h0000 || wr_drop !== 1'b0) begin
      failures++;
      $display("FAIL busy_read valid=%b out=%h wr_drop=%b exp 0 0000 0", out_valid, dout, wr_drop);
    end
    rd_en = 1'b0;
    for (int i = 0; i < 16; i++) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_initial_sweep();
    test_write_read();
    test_write_first();
    test_clear_req();
    test_async_reset();
    test_busy_read_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
